regfile_mp_lane: RTL and testbench
==================================

// Module: regfile_mp_lane
// PURPOSE
//  Parametrised multi-port register file, successor to the 32x64 2R1W PPP regfile.
//  Two write ports and NUM_RD read ports, PPP lane-masked writes generalised to any DATA_WIDTH.
//  Same-cycle write-to-read bypass, optional registered reads, and a sequential clear-sweep FSM.
//  Sits in the CPU decode/writeback path.
// PARAMETERS
//  DEPTH       32               number of registers
//  DATA_WIDTH  64               bits per register; multiple of 16; bit 0 = MSB
//  ADDR_WIDTH  $clog2(DEPTH)    address width
//  NUM_RD      2                number of read ports (>=1)
//  ZERO_REG    1                1: R0 reads 0, writes to R0 dropped
//  REG_RD      0                0: combinational read; 1: read data registered (1-cycle latency)
// PORTS
//  clk       in   1                    clock, all state on posedge
//  reset     in   1                    synchronous, ACTIVE-LOW reset
//  wrEnA     in   1                    write port A enable
//  wrAddrA   in   ADDR_WIDTH           write port A address
//  pppA      in   3                    write port A lane mode
//  dataInA   in   DATA_WIDTH           write port A data
//  wrEnB/wrAddrB/pppB/dataInB          write port B, same as A
//  rdAddr    in   NUM_RD*ADDR_WIDTH    read addresses; port k = slice k (port 0 MSBs)
//  dataOut   out  NUM_RD*DATA_WIDTH    read data, same slicing
//  clrReq    in   1                    start clear sweep
//  busy      out  1                    sweep in progress
//  pppErr    out  1                    1-cycle pulse: enabled write with illegal ppp
// BEHAVIOUR
//  - PPP byte masks: 000 all bytes; 001 upper half [0:W/2-1]; 010 lower half [W/2:W-1];
//    011 even bytes (0,2,4..); 100 odd bytes (1,3,5..). Unmasked bytes keep old value.
//  - ppp 101-111 with wrEn=1: write dropped; pppErr=1 on the next cycle. Both ports bad: one pulse.
//  - Writes commit at posedge. A and B to same address: per-byte merge; B wins overlapping bytes.
//  - Read of address X = stored X, overlaid with the same-cycle A then B lane writes to X (bypass).
//  - ZERO_REG=1: address 0 always reads 0, no bypass, writes to it dropped (pppErr still checked).
//  - REG_RD=1: dataOut = previous cycle's combinational read value (bypass included).
//  - Reset (reset==0 at posedge): all entries 0, FSM->IDLE, busy=0, pppErr=0, dataOut regs 0.
//    Reset wins over any write, clrReq or sweep in that cycle.
//  - FSM IDLE: clrReq=1 -> SWEEP, cnt = ZERO_REG?1:0; busy=1 from the next cycle.
//  - FSM SWEEP: entry cnt zeroed each cycle, cnt++. After entry DEPTH-1 -> IDLE; busy=0 next cycle.
//    Sweep length: DEPTH-ZERO_REG cycles.
//  - During SWEEP: write ports ignored; no bypass; pppErr not raised; clrReq ignored.
//    Reads return stored values; already-swept entries read 0.
//  - cnt is ADDR_WIDTH+1 bits so DEPTH = 2^ADDR_WIDTH terminates without wrap.
// TESTING
//  - Reset low 1 cycle, then read all addresses -> all 0, busy=0, pppErr=0.
//  - A: R5 <= 0x0123456789ABCDEF ppp=000; next, A: R5 ppp=011 data all-FF
//    -> R5 = 0xFF23FF67FFABFFEF; same-cycle read of R5 shows it via bypass.
//  - Same cycle: A R7 ppp=001 data 0xAAAA..., B R7 ppp=000 data 0x5555... -> R7 = 0x5555...;
//    A R0 write -> R0 still reads 0.
//  - A wrEn, ppp=110 -> no state change; pppErr high exactly 1 cycle.
//  - Fill all regs nonzero; clrReq 1 cycle -> busy high DEPTH-1 cycles; writes during sweep dropped;
//    all reads 0 after. Reset mid-sweep -> busy=0 next cycle, all regs 0.
//  - REG_RD=1, NUM_RD=4: write R3 and read R3 on all ports in same cycle
//    -> new value on dataOut next cycle.

Source files
------------

// File: rtl/regfile_mp_lane.sv
// ---------------------------------------------------------------------------
// regfile_mp_lane
//   Parametrised multi-port register file for the decode/writeback path.
//   Two lane-masked write ports (A, B) and NUM_RD read ports. Each read port
//   sees same-cycle writes through a bypass: stored value, then port A's lanes,
//   then port B's lanes. A clear request starts a sequential sweep that zeroes
//   one entry per cycle.
//
//   Data byte 0 is the most significant byte (bits DATA_WIDTH-1 .. DATA_WIDTH-8).
//
// Ports
//   clk                         clock, all state on rising edge
//   reset                       synchronous active-low reset
//   wrEnA/wrAddrA/pppA/dataInA  write port A: enable, address, lane mode, data
//   wrEnB/wrAddrB/pppB/dataInB  write port B, same meaning; B wins overlapping bytes
//   rdAddr   [NUM_RD*ADDR_WIDTH]  read addresses, port 0 in the MSB slice
//   dataOut  [NUM_RD*DATA_WIDTH]  read data, same slicing as rdAddr
//   clrReq                      start the clear sweep (ignored while sweeping)
//   busy                        sweep in progress
//   pppErr                      one-cycle pulse after an enabled write with an
//                               illegal lane mode (101..111)
// ---------------------------------------------------------------------------
module regfile_mp_lane #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit REG_RD     = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wrEnA,
    input  logic [ADDR_WIDTH-1:0]          wrAddrA,
    input  logic [2:0]                     pppA,
    input  logic [DATA_WIDTH-1:0]          dataInA,
    input  logic                           wrEnB,
    input  logic [ADDR_WIDTH-1:0]          wrAddrB,
    input  logic [2:0]                     pppB,
    input  logic [DATA_WIDTH-1:0]          dataInB,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rdAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   dataOut,
    input  logic                           clrReq,
    output logic                           busy,
    output logic                           pppErr
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // The sweep counter carries one extra bit so DEPTH == 2**ADDR_WIDTH
    // reaches its last entry without wrapping.
    localparam logic [ADDR_WIDTH:0] CNT_FIRST = ZERO_REG ? {{ADDR_WIDTH{1'b0}}, 1'b1}
                                                         : {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] CNT_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // Byte-enable pattern of a lane mode; bit b enables byte b (byte 0 = MSB byte).
    function automatic logic [NUM_BYTES-1:0] pppByteMask(input logic [2:0] ppp);
        logic [NUM_BYTES-1:0] mask;
        mask = {NUM_BYTES{1'b0}};
        for (int b = 0; b < NUM_BYTES; b++) begin
            case (ppp)
                3'b000:  mask[b] = 1'b1;
                3'b001:  mask[b] = (b < NUM_BYTES / 2);
                3'b010:  mask[b] = (b >= NUM_BYTES / 2);
                3'b011:  mask[b] = ~b[0];
                3'b100:  mask[b] = b[0];
                default: mask[b] = 1'b0;
            endcase
        end
        return mask;
    endfunction

    // Replace the enabled bytes of base with the corresponding bytes of wdata.
    function automatic logic [DATA_WIDTH-1:0] applyLanes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [NUM_BYTES-1:0]  mask
    );
        logic [DATA_WIDTH-1:0] result;
        result = base;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (mask[b]) begin
                result[DATA_WIDTH-1-8*b -: 8] = wdata[DATA_WIDTH-1-8*b -: 8];
            end else begin
                result[DATA_WIDTH-1-8*b -: 8] = base[DATA_WIDTH-1-8*b -: 8];
            end
        end
        return result;
    endfunction

    state_e                  state_r;
    state_e                  nextState_s;
    logic [ADDR_WIDTH:0]     cnt_r;
    logic [ADDR_WIDTH:0]     nextCnt_s;
    logic                    busy_r;
    logic                    pppErr_r;
    logic [DATA_WIDTH-1:0]   regArray_r [DEPTH];
    logic [DATA_WIDTH-1:0]   regNext_s  [DEPTH];

    logic                    sweeping_s;
    logic                    wrAValid_s;
    logic                    wrBValid_s;
    logic                    pppBad_s;
    logic [NUM_BYTES-1:0]    maskA_s;
    logic [NUM_BYTES-1:0]    maskB_s;

    assign sweeping_s = (state_r == SWEEP);
    assign maskA_s    = pppByteMask(pppA);
    assign maskB_s    = pppByteMask(pppB);

    // A write lands only with a legal mode, outside a sweep, and never into R0
    // when it is hardwired; the illegal-mode check does not care about R0.
    assign wrAValid_s = wrEnA && (pppA <= 3'd4) && !sweeping_s
                        && !(ZERO_REG && (wrAddrA == {ADDR_WIDTH{1'b0}}));
    assign wrBValid_s = wrEnB && (pppB <= 3'd4) && !sweeping_s
                        && !(ZERO_REG && (wrAddrB == {ADDR_WIDTH{1'b0}}));
    assign pppBad_s   = !sweeping_s
                        && ((wrEnA && (pppA > 3'd4)) || (wrEnB && (pppB > 3'd4)));

    // Sweep FSM next-state and counter logic.
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clrReq) begin
                    nextState_s = SWEEP;
                    nextCnt_s   = CNT_FIRST;
                end else begin
                    nextState_s = IDLE;
                    nextCnt_s   = cnt_r;
                end
            end
            SWEEP: begin
                nextCnt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = SWEEP;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextCnt_s   = {(ADDR_WIDTH+1){1'b0}};
            end
        endcase
    end

    // FSM state, sweep counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {(ADDR_WIDTH+1){1'b0}};
            busy_r   <= 1'b0;
            pppErr_r <= 1'b0;
        end else begin
            state_r  <= nextState_s;
            cnt_r    <= nextCnt_s;
            busy_r   <= (nextState_s == SWEEP);
            pppErr_r <= pppBad_s;
        end
    end

    assign busy   = busy_r;
    assign pppErr = pppErr_r;

    // Next contents of the array: sweep clears one entry, otherwise A's lanes
    // then B's lanes are merged so B wins bytes both ports touch.
    always_comb begin
        regNext_s = regArray_r;
        if (sweeping_s) begin
            regNext_s[cnt_r[ADDR_WIDTH-1:0]] = {DATA_WIDTH{1'b0}};
        end else begin
            regNext_s[wrAddrA] = wrAValid_s ? applyLanes(regNext_s[wrAddrA], dataInA, maskA_s)
                                            : regNext_s[wrAddrA];
            regNext_s[wrAddrB] = wrBValid_s ? applyLanes(regNext_s[wrAddrB], dataInB, maskB_s)
                                            : regNext_s[wrAddrB];
        end
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regArray_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            regArray_r <= regNext_s;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] stored_s;
        logic [DATA_WIDTH-1:0] afterA_s;
        logic [DATA_WIDTH-1:0] afterB_s;
        logic [DATA_WIDTH-1:0] value_s;

        assign addr_s   = rdAddr[(NUM_RD-k)*ADDR_WIDTH-1 -: ADDR_WIDTH];
        assign stored_s = regArray_r[addr_s];
        // Bypass: the valid flags are already low during a sweep and for R0.
        assign afterA_s = (wrAValid_s && (wrAddrA == addr_s))
                          ? applyLanes(stored_s, dataInA, maskA_s) : stored_s;
        assign afterB_s = (wrBValid_s && (wrAddrB == addr_s))
                          ? applyLanes(afterA_s, dataInB, maskB_s) : afterA_s;
        assign value_s  = (ZERO_REG && (addr_s == {ADDR_WIDTH{1'b0}}))
                          ? {DATA_WIDTH{1'b0}} : afterB_s;

        if (REG_RD) begin : gReg
            logic [DATA_WIDTH-1:0] out_r;

            // One-cycle read pipeline stage, bypass result included.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    out_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    out_r <= value_s;
                end
            end

            assign dataOut[(NUM_RD-k)*DATA_WIDTH-1 -: DATA_WIDTH] = out_r;
        end else begin : gComb
            assign dataOut[(NUM_RD-k)*DATA_WIDTH-1 -: DATA_WIDTH] = value_s;
        end
    end

endmodule

// File: tb/tb_regfile_mp_lane.sv
module tb_regfile_mp_lane;

    localparam int DEPTH = 32;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NB    = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            wrEnA;
    logic [AW-1:0]   wrAddrA;
    logic [2:0]      pppA;
    logic [DW-1:0]   dataInA;
    logic            wrEnB;
    logic [AW-1:0]   wrAddrB;
    logic [2:0]      pppB;
    logic [DW-1:0]   dataInB;
    logic            clrReq;
    logic [2*AW-1:0] rdAddr0;
    logic [2*DW-1:0] dataOut0;
    logic [4*AW-1:0] rdAddr1;
    logic [4*DW-1:0] dataOut1;
    logic            busy0;
    logic            busy1;
    logic            pppErr0;
    logic            pppErr1;

    int nCompared   = 0;
    int nMismatched = 0;
    int busyCnt;

    // Reference model state
    logic [DW-1:0] mdlMem [DEPTH];
    logic          mdlSweep;
    int            mdlIdx;
    logic          mdlErr;
    logic [DW-1:0] mdlRd1 [4];

    always #5 clk = ~clk;

    regfile_mp_lane #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_RD(2), .ZERO_REG(1'b1), .REG_RD(1'b0)
    ) dutComb (
        .clk(clk), .reset(reset),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .pppA(pppA), .dataInA(dataInA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .pppB(pppB), .dataInB(dataInB),
        .rdAddr(rdAddr0), .dataOut(dataOut0),
        .clrReq(clrReq), .busy(busy0), .pppErr(pppErr0)
    );

    regfile_mp_lane #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_RD(4), .ZERO_REG(1'b1), .REG_RD(1'b1)
    ) dutReg (
        .clk(clk), .reset(reset),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .pppA(pppA), .dataInA(dataInA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .pppB(pppB), .dataInB(dataInB),
        .rdAddr(rdAddr1), .dataOut(dataOut1),
        .clrReq(clrReq), .busy(busy1), .pppErr(pppErr1)
    );

    task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd0(input int k);
        return dataOut0[(2-k)*DW-1 -: DW];
    endfunction

    function automatic logic [DW-1:0] rd1(input int k);
        return dataOut1[(4-k)*DW-1 -: DW];
    endfunction

    // Does lane mode ppp write byte b (byte 0 = most significant)?
    function automatic bit laneOn(input logic [2:0] ppp, input int b);
        case (ppp)
            3'd0:    return 1'b1;
            3'd1:    return b < NB / 2;
            3'd2:    return b >= NB / 2;
            3'd3:    return (b % 2) == 0;
            3'd4:    return (b % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] overlay(input logic [DW-1:0] base, input logic [DW-1:0] d,
                                              input logic [2:0] ppp);
        logic [DW-1:0] r;
        r = base;
        for (int b = 0; b < NB; b++)
            if (laneOn(ppp, b)) r[DW-1-8*b -: 8] = d[DW-1-8*b -: 8];
        return r;
    endfunction

    function automatic bit goodWr(input logic en, input logic [AW-1:0] addr, input logic [2:0] ppp);
        return en && (ppp <= 3'd4) && (addr != 0);
    endfunction

    // What a combinational read of addr should show right now
    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr);
        logic [DW-1:0] v;
        if (addr == 0) return '0;
        v = mdlMem[addr];
        if (!mdlSweep) begin
            if (goodWr(wrEnA, wrAddrA, pppA) && wrAddrA == addr) v = overlay(v, dataInA, pppA);
            if (goodWr(wrEnB, wrAddrB, pppB) && wrAddrB == addr) v = overlay(v, dataInB, pppB);
        end
        return v;
    endfunction

    task automatic mdlClear();
        for (int i = 0; i < DEPTH; i++) mdlMem[i] = '0;
        mdlSweep = 1'b0;
        mdlIdx   = 0;
        mdlErr   = 1'b0;
        for (int k = 0; k < 4; k++) mdlRd1[k] = '0;
    endtask

    task automatic setIdle();
        reset   = 1'b1;
        clrReq  = 1'b0;
        wrEnA   = 1'b0; wrAddrA = '0; pppA = 3'd0; dataInA = '0;
        wrEnB   = 1'b0; wrAddrB = '0; pppB = 3'd0; dataInB = '0;
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic runCycle();
        logic [DW-1:0] rd1Now [4];
        logic          errNext;
        @(negedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++)
                checkVal($sformatf("rdComb%0d", k), rd0(k), modelRead(rdAddr0[(2-k)*AW-1 -: AW]));
        end
        for (int k = 0; k < 4; k++)
            checkVal($sformatf("rdReg%0d", k), rd1(k), mdlRd1[k]);
        checkVal("busyComb", 64'(busy0), 64'(mdlSweep));
        checkVal("busyReg", 64'(busy1), 64'(mdlSweep));
        checkVal("pppErrComb", 64'(pppErr0), 64'(mdlErr));
        checkVal("pppErrReg", 64'(pppErr1), 64'(mdlErr));
        for (int k = 0; k < 4; k++) rd1Now[k] = modelRead(rdAddr1[(4-k)*AW-1 -: AW]);
        errNext = !mdlSweep && ((wrEnA && pppA > 3'd4) || (wrEnB && pppB > 3'd4));
        @(posedge clk);
        if (!reset) begin
            mdlClear();
        end else if (mdlSweep) begin
            mdlMem[mdlIdx] = '0;
            mdlIdx++;
            if (mdlIdx == DEPTH) mdlSweep = 1'b0;
            mdlErr = 1'b0;
            for (int k = 0; k < 4; k++) mdlRd1[k] = rd1Now[k];
        end else begin
            if (goodWr(wrEnA, wrAddrA, pppA)) mdlMem[wrAddrA] = overlay(mdlMem[wrAddrA], dataInA, pppA);
            if (goodWr(wrEnB, wrAddrB, pppB)) mdlMem[wrAddrB] = overlay(mdlMem[wrAddrB], dataInB, pppB);
            mdlErr = errNext;
            if (clrReq) begin
                mdlSweep = 1'b1;
                mdlIdx   = 1;
            end
            for (int k = 0; k < 4; k++) mdlRd1[k] = rd1Now[k];
        end
        #1;
    endtask

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(0, 2))
            0:       return wrAddrA;
            1:       return wrAddrB;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic randomReads();
        for (int k = 0; k < 2; k++) rdAddr0[(2-k)*AW-1 -: AW] = pickAddr();
        for (int k = 0; k < 4; k++) rdAddr1[(4-k)*AW-1 -: AW] = pickAddr();
    endtask

    task automatic readAllZero(input string tag);
        for (int a = 0; a < DEPTH / 2; a++) begin
            rdAddr0 = {AW'(2 * a), AW'(2 * a + 1)};
            rdAddr1 = {rdAddr0, rdAddr0};
            #1;
            checkVal(tag, rd0(0), 64'd0);
            checkVal(tag, rd0(1), 64'd0);
            runCycle();
        end
    endtask

    task automatic fillAll();
        for (int i = 0; i < DEPTH; i++) begin
            setIdle();
            wrEnA   = 1'b1;
            wrAddrA = AW'(i);
            pppA    = 3'd0;
            dataInA = {$urandom, $urandom} | 64'd1;
            runCycle();
        end
        setIdle();
    endtask

    initial begin
        setIdle();
        rdAddr0 = '0;
        rdAddr1 = '0;
        mdlClear();

        // Reset for one cycle
        reset = 1'b0;
        @(posedge clk);
        mdlClear();
        #1;
        reset = 1'b1;
        checkVal("rstBusy", 64'(busy0), 64'd0);
        checkVal("rstPppErr", 64'(pppErr0), 64'd0);
        readAllZero("rstRead");

        // Full write then even-byte overwrite of R5, seen through bypass
        setIdle();
        wrEnA = 1'b1; wrAddrA = 5'd5; pppA = 3'd0; dataInA = 64'h0123456789ABCDEF;
        rdAddr0 = {5'd5, 5'd5};
        runCycle();
        pppA = 3'd3; dataInA = 64'hFFFFFFFFFFFFFFFF;
        #1 checkVal("bypassR5", rd0(0), 64'hFF23FF67FFABFFEF);
        runCycle();
        setIdle();
        #1 checkVal("storedR5", rd0(1), 64'hFF23FF67FFABFFEF);
        runCycle();

        // Same-address merge: B full write covers A's upper half
        wrEnA = 1'b1; wrAddrA = 5'd7; pppA = 3'd1; dataInA = 64'hAAAAAAAAAAAAAAAA;
        wrEnB = 1'b1; wrAddrB = 5'd7; pppB = 3'd0; dataInB = 64'h5555555555555555;
        rdAddr0 = {5'd7, 5'd8};
        runCycle();
        setIdle();
        #1 checkVal("mergeR7", rd0(0), 64'h5555555555555555);
        runCycle();

        // Same-address merge: B upper half over A full write
        wrEnA = 1'b1; wrAddrA = 5'd8; pppA = 3'd0; dataInA = 64'hAAAAAAAAAAAAAAAA;
        wrEnB = 1'b1; wrAddrB = 5'd8; pppB = 3'd1; dataInB = 64'h5555555555555555;
        #1 checkVal("bypMergeR8", rd0(1), 64'h55555555AAAAAAAA);
        runCycle();
        setIdle();
        #1 checkVal("mergeR8", rd0(1), 64'h55555555AAAAAAAA);
        runCycle();

        // R0 is hardwired
        wrEnA = 1'b1; wrAddrA = 5'd0; pppA = 3'd0; dataInA = 64'hDEADBEEF12345678;
        rdAddr0 = {5'd0, 5'd0};
        #1 checkVal("r0Bypass", rd0(0), 64'd0);
        runCycle();
        setIdle();
        #1 checkVal("r0Stored", rd0(1), 64'd0);
        runCycle();

        // Illegal lane modes on both ports: dropped, single-cycle error pulse
        wrEnA = 1'b1; wrAddrA = 5'd9; pppA = 3'd6; dataInA = 64'h1111111111111111;
        wrEnB = 1'b1; wrAddrB = 5'd9; pppB = 3'd7; dataInB = 64'h2222222222222222;
        rdAddr0 = {5'd9, 5'd9};
        #1 checkVal("badBypass", rd0(0), 64'd0);
        runCycle();
        setIdle();
        #1 checkVal("pppErrPulse", 64'(pppErr0), 64'd1);
        checkVal("badDropped", rd0(0), 64'd0);
        runCycle();
        #1 checkVal("pppErrEnd", 64'(pppErr0), 64'd0);

        // Randomized traffic, including occasional resets and clears
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 99) != 0);
            clrReq  = ($urandom_range(0, 49) == 0);
            wrEnA   = 1'($urandom_range(0, 1));
            wrAddrA = AW'($urandom);
            pppA    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            dataInA = {$urandom, $urandom};
            wrEnB   = 1'($urandom_range(0, 1));
            wrAddrB = ($urandom_range(0, 3) == 0) ? wrAddrA : AW'($urandom);
            pppB    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            dataInB = {$urandom, $urandom};
            randomReads();
            runCycle();
        end

        // Let any sweep started by the random phase finish
        setIdle();
        for (int n = 0; n < 2 * DEPTH && mdlSweep; n++) runCycle();

        // Full clear sweep with writes hammering during it
        fillAll();
        clrReq = 1'b1;
        runCycle();
        clrReq = 1'b0;
        busyCnt = 0;
        for (int n = 0; n < 100; n++) begin
            if (busy0 !== 1'b1) break;
            wrEnA = 1'b1; wrAddrA = AW'($urandom); pppA = 3'($urandom_range(0, 7)); dataInA = {$urandom, $urandom};
            wrEnB = 1'b1; wrAddrB = AW'($urandom); pppB = 3'd0; dataInB = {$urandom, $urandom};
            clrReq = 1'($urandom_range(0, 1));
            randomReads();
            runCycle();
            busyCnt++;
        end
        setIdle();
        checkVal("sweepLen", 64'(busyCnt), 64'(DEPTH - 1));
        readAllZero("sweptRead");

        // Reset in the middle of a sweep, with a write in the reset cycle
        fillAll();
        clrReq = 1'b1;
        runCycle();
        clrReq = 1'b0;
        repeat (5) runCycle();
        reset = 1'b0;
        wrEnA = 1'b1; wrAddrA = 5'd12; pppA = 3'd0; dataInA = 64'hFFFFFFFFFFFFFFFF;
        runCycle();
        setIdle();
        #1 checkVal("midRstBusy", 64'(busy0), 64'd0);
        readAllZero("midRstRead");

        // Registered read: same-cycle write shows on all four ports next cycle
        wrEnA = 1'b1; wrAddrA = 5'd3; pppA = 3'd0; dataInA = 64'hDEADBEEFCAFEF00D;
        rdAddr1 = {4{5'd3}};
        runCycle();
        setIdle();
        #1;
        for (int k = 0; k < 4; k++) checkVal($sformatf("regRdPort%0d", k), rd1(k), 64'hDEADBEEFCAFEF00D);
        runCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
